// File: rtl/packet_queue_bank.sv
// Bank of NUMBER_OF_QUEUES circular packet FIFOs: id-steered enqueue, scheduler-selected dequeue.
// Optional stall accounting (stall_cycles, drop_hint) under `PACKET_QUEUE_BANK_STALL_STATS_EN.

module packet_queue_bank_lane #(
    parameter int DATA_SIZE   = 512,
    parameter int QUEUE_DEPTH = 8,
    parameter int CNT_W       = 4,
    parameter int PTR_W       = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  logic                 pop,
    input  logic [DATA_SIZE-1:0] push_data,
    output logic [DATA_SIZE-1:0] head,
    output logic [CNT_W-1:0]     count
);
    logic [DATA_SIZE-1:0] mem [QUEUE_DEPTH];
    logic [PTR_W-1:0]     wp;
    logic [PTR_W-1:0]     rp;

    // Explicit wrap so depths that are not a power of two work.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(QUEUE_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push) wp <= next_ptr(wp);
            if (pop)  rp <= next_ptr(rp);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Payload storage carries no reset; only pointers and counts define validity.
    always_ff @(posedge clk) begin
        if (push) mem[wp] <= push_data;
    end

    assign head = mem[rp];
endmodule

module packet_queue_bank #(
    parameter int DATA_SIZE        = 512,
    parameter int NUMBER_OF_QUEUES = 4,
    parameter int QUEUE_DEPTH      = 8,
    localparam int ID_W            = $clog2(NUMBER_OF_QUEUES),
    localparam int CNT_W           = $clog2(QUEUE_DEPTH + 1)
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   queues_valid,
    output logic                                   queues_ready,
    input  logic [ID_W-1:0]                        queues_id,
    input  logic [DATA_SIZE-1:0]                   queues_packet,
    input  logic [ID_W-1:0]                        sched_id,
    input  logic                                   sched_ready,
    output logic                                   sched_valid,
    output logic [DATA_SIZE-1:0]                   sched_packet,
    output logic [NUMBER_OF_QUEUES-1:0]            queue_nonempty,
    output logic [NUMBER_OF_QUEUES-1:0][CNT_W-1:0] queue_count
`ifdef PACKET_QUEUE_BANK_STALL_STATS_EN
    ,
    output logic [31:0]                            stall_cycles,
    output logic [NUMBER_OF_QUEUES-1:0]            drop_hint
`endif
);
    localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;

    logic [NUMBER_OF_QUEUES-1:0][DATA_SIZE-1:0] head;
    logic [NUMBER_OF_QUEUES-1:0]                lane_push;
    logic [NUMBER_OF_QUEUES-1:0]                lane_pop;
    logic                                       push_fire;
    logic                                       pop_fire;

    // Ready/valid select on the id alone; an out-of-range id reads as not ready / not valid.
    always_comb begin
        queues_ready = 1'b0;
        sched_valid  = 1'b0;
        sched_packet = head[0];
        for (int q = 0; q < NUMBER_OF_QUEUES; q++) begin
            if (queues_id == ID_W'(q)) queues_ready = (queue_count[q] != CNT_W'(QUEUE_DEPTH));
            if (sched_id == ID_W'(q)) begin
                sched_valid  = (queue_count[q] != '0);
                sched_packet = head[q];
            end
        end
    end

    assign push_fire = queues_valid && queues_ready;
    assign pop_fire  = sched_valid && sched_ready;

    for (genvar q = 0; q < NUMBER_OF_QUEUES; q++) begin : g_lane
        assign lane_push[q]      = push_fire && (queues_id == ID_W'(q));
        assign lane_pop[q]       = pop_fire && (sched_id == ID_W'(q));
        assign queue_nonempty[q] = (queue_count[q] != '0);

        packet_queue_bank_lane #(
            .DATA_SIZE  (DATA_SIZE),
            .QUEUE_DEPTH(QUEUE_DEPTH),
            .CNT_W      (CNT_W),
            .PTR_W      (PTR_W)
        ) u_lane (
            .clk      (clk),
            .reset    (reset),
            .push     (lane_push[q]),
            .pop      (lane_pop[q]),
            .push_data(queues_packet),
            .head     (head[q]),
            .count    (queue_count[q])
        );
    end

`ifdef PACKET_QUEUE_BANK_STALL_STATS_EN
    logic stall;
    assign stall = queues_valid && !queues_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles <= '0;
            drop_hint    <= '0;
        end else if (stall) begin
            if (stall_cycles != 32'hFFFF_FFFF) stall_cycles <= stall_cycles + 32'd1;
            for (int q = 0; q < NUMBER_OF_QUEUES; q++)
                if (queues_id == ID_W'(q)) drop_hint[q] <= 1'b1;
        end
    end
`else
    // Stall accounting is compiled out in this build.
`endif
endmodule

// File: tb/tb_packet_queue_bank.sv
// Randomized + directed bench for packet_queue_bank: two instances (depth 8 and depth 5)
// driven in lockstep and checked every cycle against per-queue SV queue models.

module tb_packet_queue_bank;
    localparam int DW = 512;
    localparam int NQ = 4;

    logic          clk;
    logic          reset;
    logic          qv;
    logic [1:0]    qid;
    logic [DW-1:0] qpkt;
    logic [1:0]    sid;
    logic          sr;

    logic          rdy8, rdy5, sv8, sv5;
    logic [DW-1:0] sp8, sp5;
    logic [3:0]    ne8, ne5;
    logic [3:0][3:0] cnt8;
    logic [3:0][2:0] cnt5;
`ifdef PACKET_QUEUE_BANK_STALL_STATS_EN
    logic [31:0]   stc8, stc5;
    logic [3:0]    dh8, dh5;
`endif

    int checks = 0;
    int failures = 0;

    logic [DW-1:0] mq [2][NQ][$];
    logic [31:0]   stall_m [2];
    logic [3:0]    drop_m [2];

    packet_queue_bank #(.DATA_SIZE(DW), .NUMBER_OF_QUEUES(NQ), .QUEUE_DEPTH(8)) u_dut8 (
        .clk(clk), .reset(reset), .queues_valid(qv), .queues_ready(rdy8), .queues_id(qid),
        .queues_packet(qpkt), .sched_id(sid), .sched_ready(sr), .sched_valid(sv8),
        .sched_packet(sp8), .queue_nonempty(ne8), .queue_count(cnt8)
`ifdef PACKET_QUEUE_BANK_STALL_STATS_EN
        , .stall_cycles(stc8), .drop_hint(dh8)
`endif
    );

    packet_queue_bank #(.DATA_SIZE(DW), .NUMBER_OF_QUEUES(NQ), .QUEUE_DEPTH(5)) u_dut5 (
        .clk(clk), .reset(reset), .queues_valid(qv), .queues_ready(rdy5), .queues_id(qid),
        .queues_packet(qpkt), .sched_id(sid), .sched_ready(sr), .sched_valid(sv5),
        .sched_packet(sp5), .queue_nonempty(ne5), .queue_count(cnt5)
`ifdef PACKET_QUEUE_BANK_STALL_STATS_EN
        , .stall_cycles(stc5), .drop_hint(dh5)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int dep(input int d);
        return (d == 0) ? 8 : 5;
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int d = 0; d < 2; d++) begin
            for (int q = 0; q < NQ; q++) mq[d][q].delete();
            stall_m[d] = '0;
            drop_m[d]  = '0;
        end
    endtask

    task automatic check_all();
        for (int d = 0; d < 2; d++) begin
            logic r, v;
            logic [DW-1:0] p;
            logic [3:0] ne, c;
            r = (d == 0) ? rdy8 : rdy5;
            v = (d == 0) ? sv8 : sv5;
            p = (d == 0) ? sp8 : sp5;
            ne = (d == 0) ? ne8 : ne5;
            chk($sformatf("d%0d_ready_q%0d", dep(d), qid), DW'(r), DW'(mq[d][qid].size() != dep(d)));
            chk($sformatf("d%0d_valid_q%0d", dep(d), sid), DW'(v), DW'(mq[d][sid].size() != 0));
            if (mq[d][sid].size() != 0)
                chk($sformatf("d%0d_packet_q%0d", dep(d), sid), p, mq[d][sid][0]);
            for (int q = 0; q < NQ; q++) begin
                c = (d == 0) ? cnt8[q] : {1'b0, cnt5[q]};
                chk($sformatf("d%0d_count_q%0d", dep(d), q), DW'(c), DW'(mq[d][q].size()));
                chk($sformatf("d%0d_nonempty_q%0d", dep(d), q), DW'(ne[q]), DW'(mq[d][q].size() != 0));
            end
`ifdef PACKET_QUEUE_BANK_STALL_STATS_EN
            chk($sformatf("d%0d_stall_cycles", dep(d)), DW'((d == 0) ? stc8 : stc5), DW'(stall_m[d]));
            chk($sformatf("d%0d_drop_hint", dep(d)), DW'((d == 0) ? dh8 : dh5), DW'(drop_m[d]));
`endif
        end
    endtask

    // Inputs are set before the call; checks comb outputs, then advances one clock and the model.
    task automatic step();
        bit pf [2];
        bit of [2];
        bit st [2];
        #1;
        check_all();
        for (int d = 0; d < 2; d++) begin
            pf[d] = qv && (mq[d][qid].size() != dep(d));
            st[d] = qv && (mq[d][qid].size() == dep(d));
            of[d] = sr && (mq[d][sid].size() != 0);
        end
        @(posedge clk);
        if (!reset) begin
            for (int d = 0; d < 2; d++) begin
                if (pf[d]) mq[d][qid].push_back(qpkt);
                if (of[d]) void'(mq[d][sid].pop_front());
                if (st[d]) begin
                    if (stall_m[d] != 32'hFFFF_FFFF) stall_m[d]++;
                    drop_m[d][qid] = 1'b1;
                end
            end
        end
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] id, input logic [DW-1:0] pkt,
                         input logic [1:0] s, input logic r);
        qv = v; qid = id; qpkt = pkt; sid = s; sr = r;
        step();
    endtask

    function automatic logic [DW-1:0] rnd_pkt();
        logic [DW-1:0] x;
        for (int i = 0; i < DW / 32; i++) x[i*32 +: 32] = $urandom;
        return x;
    endfunction

    initial begin
        reset = 1'b1; qv = 0; qid = 0; qpkt = '0; sid = 0; sr = 0;
        model_clear();
        step();
        step();
        reset = 1'b0;

        // one packet into each queue, then read queue 2's head
        for (int i = 0; i < 4; i++) drive(1, 2'(i), DW'(8'hA0 + i), 0, 0);
        drive(0, 0, '0, 2, 0);
        chk("head_q2_A2", sp8, DW'(8'hA2));
        for (int i = 0; i < 4; i++) drive(0, 0, '0, 2'(i), 1);

        // fill queue 1 past capacity, check ready split between ids, then drain in order
        for (int i = 0; i < 9; i++) drive(1, 1, DW'(8'h10 + i), 0, 0);
        drive(0, 1, '0, 1, 0);
        chk("full_ready_q1", DW'(rdy8), DW'(0));
        drive(0, 0, '0, 1, 0);
        chk("ready_q0_while_q1_full", DW'(rdy8), DW'(1));
        for (int i = 0; i < 8; i++) drive(0, 0, '0, 1, 1);

        // wrap: streaming push/pop pairs through queue 3
        drive(1, 3, DW'(12'h300), 3, 0);
        for (int i = 1; i < 12; i++) drive(1, 3, DW'(12'h300 + i), 3, 1);
        drive(0, 3, '0, 3, 1);

        // same-queue push+pop at count 2, then at full
        drive(1, 0, DW'(16'hB0), 0, 0);
        drive(1, 0, DW'(16'hB1), 0, 0);
        drive(1, 0, DW'(16'hB2), 0, 1);
        chk("pp_count_q0", DW'(cnt8[0]), DW'(2));
        for (int i = 0; i < 8; i++) drive(1, 1, DW'(16'hC0 + i), 0, 0);
        drive(1, 1, DW'(16'hCF), 1, 1);
        chk("full_pp_count_q1", DW'(cnt8[1]), DW'(7));

`ifdef PACKET_QUEUE_BANK_STALL_STATS_EN
        reset = 1'b1; model_clear(); step(); reset = 1'b0;
        for (int i = 0; i < 8; i++) drive(1, 1, DW'(i), 0, 0);
        // dut5 already stalled 3 cycles during the fill; the model tracks that separately
        for (int i = 0; i < 10; i++) drive(1, 1, DW'(8'hEE), 0, 0);
        drive(0, 0, '0, 0, 0);
        chk("stall_cycles_10", DW'(stc8), DW'(10));
        chk("drop_hint_0010", DW'(dh8), DW'(4'b0010));
`endif

        // randomized traffic
        for (int i = 0; i < 600; i++)
            drive($urandom_range(0, 3) != 0, 2'($urandom), rnd_pkt(), 2'($urandom),
                  $urandom_range(0, 2) == 0);

        // async reset mid-burst with queue 2 holding 3 packets
        for (int i = 0; i < 4; i++) drive(0, 0, '0, 2'(i), 0);
        for (int q = 0; q < NQ; q++) for (int k = 0; k < 8; k++) drive(0, 0, '0, 2'(q), 1);
        for (int i = 0; i < 3; i++) drive(1, 2, DW'(16'hD0 + i), 2, 0);
        qv = 1; qid = 2; qpkt = DW'(16'hDD); sid = 2; sr = 0;
        #2;
        reset = 1'b1;
        #1;
        chk("async_count_q2", DW'(cnt8[2]), DW'(0));
        chk("async_valid", DW'(sv8), DW'(0));
        model_clear();
        check_all();
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive(1, 2, DW'(16'hE0), 2, 0);
        drive(1, 2, DW'(16'hE1), 2, 0);
        drive(0, 2, '0, 2, 1);
        drive(0, 2, '0, 2, 1);
        drive(0, 2, '0, 2, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
